seq_mul_div: RTL and testbench
==============================

Name: seq_mul_div

Overview:
Sequential, multi-cycle counterpart of the combinational mul_div unit. Operands are accepted through a Start/Done handshake. Unsigned multiplication uses shift-add, one multiplier bit per cycle. Unsigned division uses restoring division, one quotient bit per cycle. The block replaces the single-cycle array path where area matters, and uses the same operand and result packing so it can be swapped in behind a small controller.

Parameters:
DEVIDENT_LENGTH, 5, width of OperX (multiplicand / dividend); also sets the result width.
DIVISOR_LENGTH, 5, width of OperY (multiplier / divisor); must be <= DEVIDENT_LENGTH (elaboration-time check).

Ports:
CLK  input  1  rising-edge clock.
RST_N  input  1  asynchronous, active-low reset.
Start  input  1  request; sampled only in IDLE.
Mode  input  1  0 = multiply, 1 = divide; captured with the operands.
OperX  input  DEVIDENT_LENGTH  multiplicand / dividend.
OperY  input  DIVISOR_LENGTH  multiplier / divisor.
Busy  output  1  high in RUN and DONE.
Done  output  1  one-cycle pulse; Result is valid from this cycle.
DivByZero  output  1  set on a divide with OperY = 0; held with Result.
Result  output  2*DEVIDENT_LENGTH  product, or {remainder, quotient}.

Behaviour:
- Reset (asynchronous, RST_N = 0):
  - state = IDLE, iteration counter = 0, all datapath registers = 0.
  - Busy = 0, Done = 0, DivByZero = 0, Result = 0.
  - Reset asserted mid-operation aborts the operation immediately; no Done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with Start = 1: capture OperX, OperY and Mode; clear the accumulator; counter = 0.
  - If Mode = 1 and OperY = 0, go directly to DONE. Otherwise go to RUN.
  - Start = 0: stay in IDLE.
- RUN: one iteration per edge; the counter increments each iteration.
  - Multiply: K = DIVISOR_LENGTH iterations.
    - Examine the multiplier LSB; if it is 1, add the zero-extended multiplicand, shifted by the counter, into a 2*DEVIDENT_LENGTH accumulator.
    - Shift the multiplier right by 1.
  - Divide: K = DEVIDENT_LENGTH iterations.
    - Shift {partial remainder, dividend} left by 1.
    - Trial-subtract the divisor from the partial remainder (DIVISOR_LENGTH+1 bits wide).
    - If non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - On the edge that executes iteration K-1, load Result and go to DONE.
- DONE: Done = 1 for exactly this one cycle; next edge returns to IDLE unconditionally.
- Latency:
  - Done is visible after the K-th edge following the accept edge (multiply: 5, divide: 5 at defaults).
  - Divide-by-zero: Done is visible after the accept edge itself.
- Start handling:
  - Start in RUN or DONE is ignored, not queued.
  - Back-to-back: Start may be reasserted in the cycle after Done, when the FSM is in IDLE.
- Result packing:
  - Multiply: Result = OperX * OperY, zero-extended; the product never overflows because DIVISOR_LENGTH <= DEVIDENT_LENGTH.
  - Divide: Result[DEVIDENT_LENGTH-1:0] = quotient; Result[2*DEVIDENT_LENGTH-1:DEVIDENT_LENGTH] = remainder, zero-extended.
  - Divide-by-zero: quotient = all ones, remainder = OperX, DivByZero = 1.
- Hold rules:
  - Result and DivByZero hold from Done until the next accepted Start.
  - On that accept edge, DivByZero clears and Result holds its old value until the new Done.
- Operand inputs may change freely after the accept edge; only the captured copies are used.

Test Plan:
- Reset, then Mode=0, OperX=1, OperY=1, Start for one cycle -> Busy high; Done pulses once, 5 cycles after the accept edge; Result=1; DivByZero=0.
- Multiply OperX=2, OperY=5 -> Result=10. Then OperX=31, OperY=31 -> Result=961. Multiply OperX=0, OperY=17 -> Result=0.
- Divide OperX=31, OperY=5 -> Result={5'd1,5'd6}=38. Divide OperX=4, OperY=9 -> Result={5'd4,5'd0}=128.
- Divide OperX=7, OperY=0 -> Done after the accept edge; DivByZero=1; Result={5'd7,5'd31}=255. A following multiply 3*3 clears DivByZero on its accept edge and gives Result=9.
- Pulse Start again, with different operands, during RUN and during DONE -> ignored; exactly one Done; original result unchanged. Then reassert Start in the cycle after Done -> the new operation is accepted.
- Assert RST_N=0 mid-RUN, asynchronously between clock edges -> Busy, Done, Result and DivByZero go to 0 immediately; no Done follows; the next operation completes correctly.

Source files
------------

// File: rtl/seq_mul_div.sv
// rtl/seq_mul_div.sv - sequential shift-add multiplier / restoring divider with Start/Done handshake
//
// Purpose: multi-cycle unsigned multiply (one multiplier bit per cycle) and
// restoring divide (one quotient bit per cycle), result packed as the
// product or {remainder, quotient}.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   Start      operation request, sampled only while idle
//   Mode       0 = multiply, 1 = divide (captured with the operands)
//   OperX      multiplicand / dividend
//   OperY      multiplier / divisor
//   Busy       high while an operation is running or completing
//   Done       one-cycle completion pulse; Result valid from this cycle
//   DivByZero  divide with OperY = 0; held with Result
//   Result     product, or {remainder, quotient}
module seq_mul_div #(
  parameter int DEVIDENT_LENGTH = 5,
  parameter int DIVISOR_LENGTH  = 5
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           Start,
  input  logic                           Mode,
  input  logic [DEVIDENT_LENGTH-1:0]     OperX,
  input  logic [DIVISOR_LENGTH-1:0]      OperY,
  output logic                           Busy,
  output logic                           Done,
  output logic                           DivByZero,
  output logic [2*DEVIDENT_LENGTH-1:0]   Result
);

  localparam int DL = DEVIDENT_LENGTH;
  localparam int VL = DIVISOR_LENGTH;
  localparam int RW = 2 * DEVIDENT_LENGTH;
  localparam int CW = $clog2(DEVIDENT_LENGTH) + 1;

  generate
    if (DIVISOR_LENGTH > DEVIDENT_LENGTH) begin : g_bad_params
      $error("seq_mul_div: DIVISOR_LENGTH must not exceed DEVIDENT_LENGTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic          mode_q;
  logic [DL-1:0] x_q;
  logic [VL-1:0] y_q;
  logic [RW-1:0] acc_q;
  logic [VL-1:0] rem_q;
  logic [DL-1:0] dvd_q;
  logic [CW-1:0] cnt_q;

  logic          accept;
  logic          div_zero_in;
  logic [CW-1:0] k_last;
  logic          last_iter;

  logic [RW-1:0] mul_addend;
  logic [RW-1:0] acc_nxt;
  logic [VL:0]   shifted;
  logic [VL+1:0] trial;
  logic          q_bit;
  logic [VL-1:0] rem_nxt;
  logic [DL-1:0] dvd_nxt;
  logic [RW-1:0] res_nxt;
  logic [RW-1:0] dz_result;

  assign accept      = (state == S_IDLE) && Start;
  assign div_zero_in = Mode && (OperY == '0);
  assign k_last      = mode_q ? CW'(DL - 1) : CW'(VL - 1);
  assign last_iter   = (cnt_q == k_last);

  // Datapath for one iteration of either operation.
  always_comb begin
    mul_addend = RW'(x_q) << cnt_q;
    acc_nxt    = y_q[0] ? (acc_q + mul_addend) : acc_q;

    // Partial remainder stays below the divisor, so VL bits hold it; the
    // extra top bit of the trial difference is the borrow.
    shifted    = {rem_q, dvd_q[DL-1]};
    trial      = {1'b0, shifted} - {2'b00, y_q};
    q_bit      = ~trial[VL+1];
    rem_nxt    = q_bit ? trial[VL-1:0] : shifted[VL-1:0];
    dvd_nxt    = {dvd_q[DL-2:0], q_bit};

    res_nxt    = mode_q ? ((RW'(rem_nxt) << DL) | RW'(dvd_nxt)) : acc_nxt;
    dz_result  = (RW'(OperX) << DL) | RW'({DL{1'b1}});
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nxt = div_zero_in ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy = (state != S_IDLE);
    Done = (state == S_DONE);
  end

  // Datapath registers. Result only changes on a completing edge (or on a
  // divide-by-zero accept, which completes immediately), so it holds
  // through the next operation until that one finishes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      cnt_q     <= '0;
      DivByZero <= 1'b0;
      Result    <= '0;
    end else if (accept) begin
      mode_q    <= Mode;
      x_q       <= OperX;
      y_q       <= OperY;
      dvd_q     <= OperX;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      DivByZero <= div_zero_in;
      if (div_zero_in) begin
        Result <= dz_result;
      end
    end else if (state == S_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      if (mode_q) begin
        rem_q <= rem_nxt;
        dvd_q <= dvd_nxt;
      end else begin
        acc_q <= acc_nxt;
        y_q   <= y_q >> 1;
      end
      if (last_iter) begin
        Result <= res_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// tb/tb_seq_mul_div.sv - scoreboard testbench for seq_mul_div
module tb_seq_mul_div;

  localparam int DL = 5;
  localparam int VL = 5;
  localparam int RW = 2 * DL;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          Start = 1'b0;
  logic          Mode = 1'b0;
  logic [DL-1:0] OperX = '0;
  logic [VL-1:0] OperY = '0;
  logic          Busy;
  logic          Done;
  logic          DivByZero;
  logic [RW-1:0] Result;

  seq_mul_div #(
    .DEVIDENT_LENGTH(DL),
    .DIVISOR_LENGTH (VL)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Start    (Start),
    .Mode     (Mode),
    .OperX    (OperX),
    .OperY    (OperY),
    .Busy     (Busy),
    .Done     (Done),
    .DivByZero(DivByZero),
    .Result   (Result)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    longint res;
    bit     dz;
    int     done_cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     vectors = 0;
  int     miscompares = 0;
  longint held = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (RST_N && Done) begin
      if (sb.size() == 0) begin
        check("done_without_request", longint'(Done), 0);
      end else begin
        mon_e = sb.pop_front();
        check("result", longint'(Result), mon_e.res);
        check("div_by_zero", longint'(DivByZero), longint'(mon_e.dz));
        check("done_cycle", longint'(cyc), longint'(mon_e.done_cyc));
      end
    end
  end

  // Waits for idle, computes the expected outcome from plain arithmetic,
  // queues it, and applies Start for one accept edge.
  task automatic issue(input bit m, input int x, input int y);
    exp_t e;
    int   n;
    n = 0;
    @(negedge CLK);
    while (Busy && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check("idle_before_issue", longint'(Busy), 0);
    if (Busy) return;
    e.dz = m && (y == 0);
    if (!m)
      e.res = longint'(x * y);
    else if (y == 0)
      e.res = (longint'(x) << DL) | ((longint'(1) << DL) - 1);
    else
      e.res = (longint'(x % y) << DL) | longint'(x / y);
    e.done_cyc = cyc + 1 + (e.dz ? 0 : (m ? DL : VL));
    sb.push_back(e);
    Start = 1'b1;
    Mode  = m;
    OperX = DL'(x);
    OperY = VL'(y);
    @(posedge CLK);
    #1;
    Start = 1'b0;
    OperX = DL'($urandom);
    OperY = VL'($urandom);
    Mode  = 1'($urandom);
    check("busy_after_accept", longint'(Busy), 1);
    check("dz_on_accept", longint'(DivByZero), longint'(e.dz));
    check("result_on_accept", longint'(Result), e.dz ? e.res : held);
    held = e.res;
  endtask

  initial begin
    int n;
    bit m;
    int x;
    int y;

    repeat (2) @(negedge CLK);
    check("reset_busy", longint'(Busy), 0);
    check("reset_done", longint'(Done), 0);
    check("reset_result", longint'(Result), 0);
    check("reset_dbz", longint'(DivByZero), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("idle_busy", longint'(Busy), 0);

    issue(0, 1, 1);
    issue(0, 2, 5);
    issue(0, 31, 31);
    issue(0, 0, 17);
    issue(1, 31, 5);
    issue(1, 4, 9);
    issue(1, 7, 0);
    issue(0, 3, 3);

    // Start pulses during RUN and DONE must be ignored.
    issue(0, 6, 7);
    @(negedge CLK);
    Start = 1'b1; Mode = 1'b1; OperX = 5'd9; OperY = 5'd2;
    @(negedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    n = 0;
    while (!Done && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("done_seen", longint'(Done), 1);
    Start = 1'b1; Mode = 1'b0; OperX = 5'd31; OperY = 5'd31;
    issue(1, 29, 3);

    // Asynchronous reset in the middle of a run.
    issue(0, 13, 11);
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check("abort_busy", longint'(Busy), 0);
    check("abort_done", longint'(Done), 0);
    check("abort_result", longint'(Result), 0);
    check("abort_dbz", longint'(DivByZero), 0);
    sb.delete();
    held = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) @(negedge CLK);
    check("idle_after_abort", longint'(Busy), 0);
    issue(0, 13, 11);
    issue(1, 30, 4);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom);
      x = int'($urandom_range(0, (1 << DL) - 1));
      if ($urandom_range(0, 7) == 0)
        y = 0;
      else
        y = int'($urandom_range(0, (1 << VL) - 1));
      issue(m, x, y);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("scoreboard_drained", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
